// File: rtl/pcie_arb_pkg.sv
// Shared types for the channel-FIFO drain arbiter: channel count, FSM encoding
// and the channel index type.
package pcie_arb_pkg;

  localparam int NUM_VC = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2,
    ST_INIT  = 2'd3
  } arb_state_t;

  typedef logic [2:0] vc_idx_t;

endpackage

// File: rtl/vc_drain_arbiter_if.sv
// Bundle between the arbiter, the eight channel FIFOs, the downstream FIFO and
// the link-control FSM. The arbiter side is the slave modport.
interface vc_drain_arbiter_if #(
  parameter int DATA_WIDTH   = 6,
  parameter int UMBRALES_L_H = 8
);
  logic                      init;
  logic [UMBRALES_L_H-1:0]   umbral_L;
  logic [UMBRALES_L_H-1:0]   umbral_H;
  logic [7:0]                empty_fifo;
  logic [8*DATA_WIDTH-1:0]   data_in;
  logic [UMBRALES_L_H-1:0]   dest_count;
  logic [7:0]                pop;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      valid_out;
  logic                      pause;
  logic [2:0]                grant_idx;

  modport slave (
    input  init, umbral_L, umbral_H, empty_fifo, data_in, dest_count,
    output pop, data_out, valid_out, pause, grant_idx
  );

  modport master (
    output init, umbral_L, umbral_H, empty_fifo, data_in, dest_count,
    input  pop, data_out, valid_out, pause, grant_idx
  );
endinterface

// File: rtl/rr_picker.sv
// Rotating find-first-set: the first requester after i_ptr (wrapping, ending at
// i_ptr itself) wins. Purely combinational.
module rr_picker
  import pcie_arb_pkg::*;
(
  input  logic [NUM_VC-1:0] i_req,
  input  vc_idx_t           i_ptr,
  output logic [NUM_VC-1:0] o_gnt,
  output vc_idx_t           o_idx,
  output logic              o_any
);

  logic    w_found;
  vc_idx_t w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_any   = |i_req;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_VC; k++) begin
      // k == NUM_VC wraps to i_ptr itself, the lowest-priority slot.
      w_cand = i_ptr + vc_idx_t'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found        = 1'b1;
        o_idx          = w_cand;
        o_gnt[w_cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_drain_arbiter.sv
// Drains eight channel FIFOs into one downstream FIFO, one word per cycle,
// round-robin, throttled by hysteresis on downstream occupancy.
// Define VC0_PRIORITY_EN to make channel 0 strict priority over channels 1-7.
module vc_drain_arbiter
  import pcie_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 6,
  parameter int UMBRALES_L_H = 8
) (
  input  logic              clk,
  input  logic              reset,
  vc_drain_arbiter_if.slave bus,
  output arb_state_t        o_dbg_state
);

  // Handshake: pop[i] is a single-cycle read strobe, the FIFO word follows one
  // cycle later; valid_out is the downstream push with no ready, backpressure
  // comes only from the pause hysteresis on dest_count.

  arb_state_t              r_state, w_state_nxt;
  logic                    r_pause;
  vc_idx_t                 r_last_grant;
  logic                    r_pop_d;
  vc_idx_t                 r_idx_d;
  logic [DATA_WIDTH-1:0]   r_data_out;
  logic                    r_valid_out;

  logic [UMBRALES_L_H-1:0] w_dest, w_thr_l, w_thr_h;
  logic [NUM_VC-1:0]       w_req, w_rr_gnt, w_pick_gnt;
  vc_idx_t                 w_rr_idx, w_pick_idx;
  logic                    w_any_req, w_pop_en, w_upd_lg;

  assign w_dest  = bus.dest_count;
  assign w_thr_l = bus.umbral_L;
  assign w_thr_h = bus.umbral_H;
  assign w_req   = ~bus.empty_fifo;

  rr_picker u_picker (
    .i_req (w_req),
    .i_ptr (r_last_grant),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx),
    .o_any (w_any_req)
  );

  assign w_pop_en = (r_state == ST_DRAIN) && !r_pause && !bus.init && !reset && w_any_req;

`ifdef VC0_PRIORITY_EN
  // Channel 0 bypasses the rotation and leaves the pointer where 1-7 left it.
  assign w_pick_gnt = w_req[0] ? 8'h01 : w_rr_gnt;
  assign w_pick_idx = w_req[0] ? vc_idx_t'(0) : w_rr_idx;
  assign w_upd_lg   = w_pop_en && !w_req[0];
`else
  assign w_pick_gnt = w_rr_gnt;
  assign w_pick_idx = w_rr_idx;
  assign w_upd_lg   = w_pop_en;
`endif

  assign bus.pop       = w_pop_en ? w_pick_gnt : '0;
  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.pause     = r_pause;
  assign bus.grant_idx = r_last_grant;
  assign o_dbg_state   = r_state;

  // Set wins over clear when the thresholds overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pause <= 1'b0;
    end else if (w_dest >= w_thr_h) begin
      r_pause <= 1'b1;
    end else if (w_dest <= w_thr_l) begin
      r_pause <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.init) begin
      w_state_nxt = ST_INIT;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_any_req && !r_pause) w_state_nxt = ST_DRAIN;
        ST_DRAIN: begin
          if (r_pause)         w_state_nxt = ST_HOLD;
          else if (!w_any_req) w_state_nxt = ST_IDLE;
        end
        ST_HOLD:  if (!r_pause) w_state_nxt = w_any_req ? ST_DRAIN : ST_IDLE;
        ST_INIT:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Two-stage read pipeline: pop edge, then capture of the FIFO's read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= vc_idx_t'(7);
      r_pop_d      <= 1'b0;
      r_idx_d      <= '0;
      r_valid_out  <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_pop_d     <= w_pop_en;
      r_valid_out <= r_pop_d;
      if (w_pop_en) r_idx_d      <= w_pick_idx;
      if (w_upd_lg) r_last_grant <= w_pick_idx;
      if (r_pop_d)  r_data_out   <= bus.data_in[32'(r_idx_d) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: doc/vc_drain_arbiter.md
# vc_drain_arbiter

Read side of the eight-FIFO PCIE datapath. It drains the eight channel FIFOs into one downstream FIFO with round-robin arbitration, one word per cycle. Flow control uses hysteresis on the downstream FIFO's occupancy, against the low/high thresholds latched by the link-control FSM. It sits between the eight channel FIFOs and the downstream FIFO, and runs alongside the control FSM that reports idle/active.

## Interface
- DATA_WIDTH, default 6: word width of every channel FIFO and of the output.
- UMBRALES_L_H, default 8: width of the thresholds and of the downstream occupancy count.

- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- init  in  1  configuration phase from the control FSM; no pops while high.
- umbral_L  in  UMBRALES_L_H  low threshold (latched FSM output).
- umbral_H  in  UMBRALES_L_H  high threshold (latched FSM output).
- empty_fifo  in  8  bit i = channel FIFO i empty.
- data_in  in  8*DATA_WIDTH  channel FIFO read data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- dest_count  in  UMBRALES_L_H  downstream FIFO occupancy.
- pop  out  8  one-hot read strobe to the channel FIFOs; all-zero when idle.
- data_out  out  DATA_WIDTH  registered output word.
- valid_out  out  1  data_out valid; this is the push to the downstream FIFO.
- pause  out  1  registered hysteresis flag.
- grant_idx  out  3  index of the most recently granted channel.

## Operation
- **States**
  - IDLE: no pops. Go to DRAIN when any empty_fifo bit is 0 and pause=0.
  - DRAIN: one pop per cycle.
    - Go to HOLD when pause=1.
    - Go to IDLE when empty_fifo=8'hFF.
  - HOLD: no pops. Go back to DRAIN when pause=0 and any channel is non-empty. Go to IDLE when pause=0 and all channels are empty.
  - INIT: no pops.
    - From any state, init=1 moves to INIT.
    - In INIT, init=0 moves to IDLE.
    - init takes priority over all other transitions.
- **Pause (registered)**
  - Set when dest_count >= umbral_H.
  - Clear when dest_count <= umbral_L.
  - Otherwise hold its value.
  - If both conditions are true (umbral_L >= umbral_H), set wins.
- **Arbitration**
  - In DRAIN with pause=0, pop bit i is asserted combinationally.
  - i is the first non-empty channel scanning last_grant+1, last_grant+2, …, wrapping 7 to 0 and ending at last_grant.
  - At most one pop bit is set at a time. An empty channel is never popped.
  - On every pop, last_grant is updated to i; grant_idx = last_grant.
- **Data path**
  - The channel FIFO presents its word one cycle after pop.
  - The block registers data_in slice[i] into data_out and sets valid_out=1 at the following edge.
- **Headroom**
  - Up to 2 words are still in flight when pause rises.
  - The downstream FIFO must have umbral_H <= depth−3. This is an integration rule; the block does not check it.

## Timing
- **Reset values**
  - state=IDLE; last_grant=7, so the first grant goes to channel 0.
  - pause=0; pop=0; data_out=0; valid_out=0; grant_idx=7.
- **Latency**
  - pop in cycle N; data_in valid in N+1; data_out/valid_out visible in N+2.
  - Sustained throughput: 1 word per cycle.
- **Pause response**
  - dest_count crosses umbral_H in cycle N; pause=1 from N+1.
  - The first cycle with pop=0 is N+1 (HOLD entered at N+2; pop is gated by pause directly).
- **Reset mid-operation**
  - pop=0 in the same cycle reset is high.
  - The in-flight pipeline stage is discarded: valid_out=0 at the next edge.
- **init mid-drain**
  - pop=0 in the cycle init is high.
  - A word already popped still completes: valid_out still pulses at N+2.
- **Channel empties in the same cycle it would be granted**: it is skipped and the next non-empty channel is granted.

## Configuration
- VC0_PRIORITY_EN
  - Defined: channel 0 is strict priority. Whenever empty_fifo[0]=0 it wins, and last_grant is not updated, so round-robin over channels 1–7 resumes where it left off.
  - Undefined: pure 8-way round-robin as above.

## Structure
- Package pcie_arb_pkg holds:
  - NUM_VC=8.
  - State encodings: IDLE=2'd0, DRAIN=2'd1, HOLD=2'd2, INIT=2'd3.
  - A typedef for the 3-bit channel index.
- Sub-module rr_picker: combinational find-first-set over an 8-bit request vector, rotated by a 3-bit pointer. Outputs a one-hot grant, its index, and an any_req flag.

## Test plan
- **Reset release, only channel 3 non-empty with 4 words, dest_count=0**
  - pop=8'h08 for 4 consecutive cycles.
  - valid_out high for 4 cycles, starting 2 cycles after the first pop.
  - Then pop=0 and state IDLE.
- **All 8 channels non-empty**
  - Grants in order 0,1,…,7,0.
  - grant_idx tracks the grants.
  - No channel is granted twice before all the others have been granted once.
- **umbral_L=4, umbral_H=10, dest_count ramped 9→10→7→4**
  - pause rises the cycle after 10 is seen and holds through 7.
  - pause falls the cycle after 4 is seen; popping resumes the following cycle.
- **init pulsed high for 3 cycles mid-drain**
  - pop=0 during the pulse, with exactly one trailing valid_out.
  - State returns via IDLE to DRAIN; round-robin resumes at last_grant+1.
- **reset asserted while popping channel 5**
  - At the next edge: pop=0, valid_out=0, data_out=0, grant_idx=7.
  - The next grant goes to the lowest non-empty channel.
- **VC0_PRIORITY_EN defined, channels 0 and 2 non-empty**
  - Channel 0 is drained completely first, then channel 2.
  - Without the macro, grants alternate 0,2,0,2.
